// File: rtl/snd_fifo_stereo_if.sv
// Stereo sample interface: producer push handshake and the popped output pair.
// Latency: none, this file only bundles the signals.
// Backpressure: wr_ready from the FIFO side stalls the producer; the pop side has no backpressure.
interface snd_fifo_stereo_if;
  logic               wr_valid;
  logic               wr_ready;
  logic signed [15:0] wr_l;
  logic signed [15:0] wr_r;
  logic               snd_next_sample;
  logic signed [15:0] snd_o_l;
  logic signed [15:0] snd_o_r;

  // Producer / output-stage side
  modport master (
    output wr_valid, wr_l, wr_r, snd_next_sample,
    input  wr_ready, snd_o_l, snd_o_r
  );

  // FIFO side
  modport slave (
    input  wr_valid, wr_l, wr_r, snd_next_sample,
    output wr_ready, snd_o_l, snd_o_r
  );
endinterface

// File: rtl/snd_fifo_stereo.sv
// Stereo PCM FIFO: DEPTH x {l,r} RAM with head register, pops one pair per snd_next_sample strobe.
// Latency: push visible in fifo_level next cycle; pair poppable by a strobe 1 cycle after the push; outputs registered.
// Backpressure: wr_ready drops at level DEPTH; a pop on empty holds outputs and sets sticky underrun.
// Optional: define SND_FIFO_STAT_EN to add the saturating 16-bit underrun_cnt output.
module snd_fifo_stereo #(
  parameter int AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  snd_fifo_stereo_if.slave    sif,
  output logic [AW:0]         fifo_level,
  output logic                low_wm,
  output logic                underrun,
  input  logic                underrun_clr
`ifdef SND_FIFO_STAT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_HALF = (AW+1)'(DEPTH / 2);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   ram_dout_q;
  logic [31:0]   byp_dat_q;
  logic          byp_sel_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          hd_vld_q;
  logic [15:0]   snd_l_q, snd_l_d;
  logic [15:0]   snd_r_q, snd_r_d;
  logic          low_wm_q;
  logic          underrun_q, underrun_d;

  logic          push;
  logic          wr_en;
  logic          pop;
  logic          ur_evt;
  logic [31:0]   wr_dat;
  logic [31:0]   head_dat;

  assign sif.wr_ready = (level_q != LVL_FULL);
  assign push         = sif.wr_valid & sif.wr_ready;
  // A push that lands in a flush cycle is dropped.
  assign wr_en        = push & ~flush;
  // hd_vld_q mirrors (level != 0): the head always holds the oldest entry when any exist.
  assign pop          = sif.snd_next_sample & hd_vld_q;
  assign ur_evt       = sif.snd_next_sample & ~hd_vld_q;
  assign wr_dat       = {sif.wr_l, sif.wr_r};
  // Head is the RAM word at rd_ptr, unless that word was written in the same cycle it was read.
  assign head_dat     = byp_sel_q ? byp_dat_q : ram_dout_q;

  // Next-state for pointers, level, outputs and the sticky underrun flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    snd_l_d    = snd_l_q;
    snd_r_d    = snd_r_q;
    underrun_d = underrun_q;

    // A pop in a flush cycle still completes before the clear.
    if (pop) begin
      snd_l_d = head_dat[31:16];
      snd_r_d = head_dat[15:0];
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Set wins over clear.
    if (ur_evt)            underrun_d = 1'b1;
    else if (underrun_clr) underrun_d = 1'b0;
  end

  // Sample RAM: write at wr_ptr, read the next head address every cycle so the head tracks it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    ram_dout_q <= mem_q[rd_ptr_d];
  end

  // Control state, write-through bypass and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hd_vld_q   <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_dat_q  <= '0;
      snd_l_q    <= '0;
      snd_r_q    <= '0;
      low_wm_q   <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hd_vld_q   <= (level_d != '0);
      // RAM returns the old word on a same-address write, so forward the new pair instead.
      byp_sel_q  <= wr_en && (wr_ptr_q == rd_ptr_d);
      byp_dat_q  <= wr_dat;
      snd_l_q    <= snd_l_d;
      snd_r_q    <= snd_r_d;
      low_wm_q   <= (level_d < LVL_HALF);
      underrun_q <= underrun_d;
    end
  end

  assign sif.snd_o_l = snd_l_q;
  assign sif.snd_o_r = snd_r_q;
  assign fifo_level  = level_q;
  assign low_wm      = low_wm_q;
  assign underrun    = underrun_q;

`ifdef SND_FIFO_STAT_EN
  logic [15:0] ur_cnt_q;

  // Saturating underrun event counter; a new event wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ur_cnt_q <= '0;
    end else if (ur_evt) begin
      if (ur_cnt_q != 16'hFFFF) ur_cnt_q <= ur_cnt_q + 1'b1;
    end else if (underrun_clr) begin
      ur_cnt_q <= '0;
    end
  end

  assign underrun_cnt = ur_cnt_q;
`endif

endmodule

// File: tb/tb_snd_fifo_stereo.sv
// Directed bench for snd_fifo_stereo with AW=8 (DEPTH=256).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-written constants or a small queue model of the FIFO contents.
module tb_snd_fifo_stereo;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        underrun_clr = 1'b0;
  logic [AW:0] fifo_level;
  logic        low_wm;
  logic        underrun;
`ifdef SND_FIFO_STAT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] ql[$];
  logic [15:0] qr[$];
  logic [15:0] el, er;
  logic        do_pop;

  snd_fifo_stereo_if sif();

  snd_fifo_stereo #(.AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .sif          (sif),
    .fifo_level   (fifo_level),
    .low_wm       (low_wm),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
`ifdef SND_FIFO_STAT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    sif.wr_valid = 1'b1;
    sif.wr_l     = l;
    sif.wr_r     = r;
    tick();
    sif.wr_valid = 1'b0;
  endtask

  task automatic strobe;
    sif.snd_next_sample = 1'b1;
    tick();
    sif.snd_next_sample = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] l, input logic [15:0] r);
    check({tag, "_l"}, sif.snd_o_l, l);
    check({tag, "_r"}, sif.snd_o_r, r);
  endtask

  initial begin
    sif.wr_valid        = 1'b0;
    sif.wr_l            = '0;
    sif.wr_r            = '0;
    sif.snd_next_sample = 1'b0;

    // Reset values while held in reset
    #12;
    check_out("rst", 16'h0000, 16'h0000);
    check("rst_level",    16'(fifo_level),   16'd0);
    check("rst_wr_ready", 16'(sif.wr_ready), 16'd1);
    check("rst_low_wm",   16'(low_wm),       16'd1);
    check("rst_underrun", 16'(underrun),     16'd0);
`ifdef SND_FIFO_STAT_EN
    check("rst_cnt", underrun_cnt, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two pairs in, two pops out in order
    push(16'h1234, 16'hEDCB);
    push(16'h7FFF, 16'h8000);
    check("lvl2", 16'(fifo_level), 16'd2);
    strobe();
    check_out("pop1", 16'h1234, 16'hEDCB);
    check("lvl1", 16'(fifo_level), 16'd1);
    strobe();
    check_out("pop2", 16'h7FFF, 16'h8000);
    check("lvl0", 16'(fifo_level), 16'd0);

    // Strobe exactly one cycle after a push into an empty FIFO
    push(16'h0100, 16'hFF00);
    strobe();
    check_out("bypass", 16'h0100, 16'hFF00);
    check("bypass_lvl", 16'(fifo_level), 16'd0);

    // Underrun holds outputs, sets the sticky flag, clear drops it
    strobe();
    check_out("ur_hold", 16'h0100, 16'hFF00);
    check("ur_flag", 16'(underrun),   16'd1);
    check("ur_lvl",  16'(fifo_level), 16'd0);
`ifdef SND_FIFO_STAT_EN
    check("ur_cnt", underrun_cnt, 16'd1);
`endif
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("ur_clr", 16'(underrun), 16'd0);
`ifdef SND_FIFO_STAT_EN
    check("ur_cnt_clr", underrun_cnt, 16'd0);
`endif

    // Fill to DEPTH with wr_valid held: l=i, r=A000|i
    sif.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sif.wr_l = 16'(i);
      sif.wr_r = 16'hA000 | 16'(i);
      tick();
      if (i == DEPTH - 2) begin
        check("fill_lvl255",  16'(fifo_level),   16'd255);
        check("fill_rdy255",  16'(sif.wr_ready), 16'd1);
      end
    end
    check("full_lvl",    16'(fifo_level),   16'd256);
    check("full_rdy",    16'(sif.wr_ready), 16'd0);
    check("full_low_wm", 16'(low_wm),       16'd0);
    sif.wr_l = 16'hDEAD;
    sif.wr_r = 16'hBEEF;
    tick();
    tick();
    check("full_no_extra", 16'(fifo_level), 16'd256);

    // Push+pop at full: pop succeeds, push refused this cycle, accepted the next
    sif.snd_next_sample = 1'b1;
    tick();
    sif.snd_next_sample = 1'b0;
    check_out("full_pop", 16'h0000, 16'hA000);
    check("full_pop_lvl", 16'(fifo_level), 16'd255);
    tick();
    sif.wr_valid = 1'b0;
    check("full_refill_lvl", 16'(fifo_level), 16'd256);

    // Drain: remaining 1..255 in order, then the late DEAD/BEEF pair
    for (int i = 1; i < DEPTH; i++) begin
      strobe();
      check_out("drain", 16'(i), 16'hA000 | 16'(i));
    end
    strobe();
    check_out("drain_last", 16'hDEAD, 16'hBEEF);
    check("drain_lvl",    16'(fifo_level), 16'd0);
    check("drain_low_wm", 16'(low_wm),     16'd1);

    // Push into an empty FIFO in the same cycle as a strobe
    sif.wr_valid        = 1'b1;
    sif.wr_l            = 16'h5555;
    sif.wr_r            = 16'hAAAA;
    sif.snd_next_sample = 1'b1;
    tick();
    sif.wr_valid        = 1'b0;
    sif.snd_next_sample = 1'b0;
    check("pp0_ur",  16'(underrun),   16'd1);
    check("pp0_lvl", 16'(fifo_level), 16'd1);
    check_out("pp0_hold", 16'hDEAD, 16'hBEEF);
`ifdef SND_FIFO_STAT_EN
    check("pp0_cnt", underrun_cnt, 16'd1);
`endif
    strobe();
    check_out("pp0_pop", 16'h5555, 16'hAAAA);
    check("pp0_lvl0", 16'(fifo_level), 16'd0);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;

    // 384 pushes with a pop every other cycle (pointer wrap, low_wm crossing), then drain
    for (int c = 0; c < 3 * DEPTH / 2; c++) begin
      sif.wr_valid        = 1'b1;
      sif.wr_l            = 16'(c);
      sif.wr_r            = ~16'(c);
      sif.snd_next_sample = (c % 2) == 1;
      do_pop = ((c % 2) == 1) && (ql.size() != 0);
      tick();
      if (do_pop) begin
        el = ql.pop_front();
        er = qr.pop_front();
        check_out("wrap_pop", el, er);
      end
      ql.push_back(16'(c));
      qr.push_back(~16'(c));
      check("wrap_lvl",    16'(fifo_level), 16'(ql.size()));
      check("wrap_low_wm", 16'(low_wm),     16'(ql.size() < DEPTH / 2));
    end
    sif.wr_valid        = 1'b0;
    sif.snd_next_sample = 1'b0;
    while (ql.size() != 0) begin
      strobe();
      el = ql.pop_front();
      er = qr.pop_front();
      check_out("wrap_drain", el, er);
      check("wrap_drain_low_wm", 16'(low_wm), 16'(ql.size() < DEPTH / 2));
    end
    check("wrap_ur", 16'(underrun), 16'd0);

    // Flush at level 5 with a push in the same cycle
    for (int k = 0; k < 5; k++) push(16'h1100 + 16'(k), 16'h2200 + 16'(k));
    check("pre_flush_lvl", 16'(fifo_level), 16'd5);
    flush        = 1'b1;
    sif.wr_valid = 1'b1;
    sif.wr_l     = 16'h7777;
    sif.wr_r     = 16'h7777;
    tick();
    flush        = 1'b0;
    sif.wr_valid = 1'b0;
    check("flush_lvl", 16'(fifo_level),   16'd0);
    check("flush_rdy", 16'(sif.wr_ready), 16'd1);
    check("flush_ur",  16'(underrun),     16'd0);
    check_out("flush_hold", 16'h017F, 16'hFE80);
    strobe();
    check("flush_empty_ur", 16'(underrun), 16'd1);
    check_out("flush_empty_hold", 16'h017F, 16'hFE80);

    // Mid-stream asynchronous reset
    push(16'h0A0A, 16'h0B0B);
    push(16'h0C0C, 16'h0D0D);
    strobe();
    check_out("pre_rst", 16'h0A0A, 16'h0B0B);
    sif.wr_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_out("arst", 16'h0000, 16'h0000);
    check("arst_lvl", 16'(fifo_level),   16'd0);
    check("arst_rdy", 16'(sif.wr_ready), 16'd1);
    check("arst_lwm", 16'(low_wm),       16'd1);
    check("arst_ur",  16'(underrun),     16'd0);
    sif.wr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_lvl", 16'(fifo_level), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
